// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Holds the funct3 operation codes, the FSM state encoding and small
// helpers that classify an operation by operand signedness and kind.
package muldiv_unit_pkg;

  typedef logic [2:0] muldiv_op_t;

  localparam muldiv_op_t MULDIV_OP_MUL    = 3'd0;
  localparam muldiv_op_t MULDIV_OP_MULH   = 3'd1;
  localparam muldiv_op_t MULDIV_OP_MULHSU = 3'd2;
  localparam muldiv_op_t MULDIV_OP_MULHU  = 3'd3;
  localparam muldiv_op_t MULDIV_OP_DIV    = 3'd4;
  localparam muldiv_op_t MULDIV_OP_DIVU   = 3'd5;
  localparam muldiv_op_t MULDIV_OP_REM    = 3'd6;
  localparam muldiv_op_t MULDIV_OP_REMU   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_FIXUP = 2'd2,
    ST_DONE  = 2'd3
  } muldiv_state_t;

  // rs1 is treated as signed (MUL itself is sign-independent in its low word,
  // so it is run as unsigned).
  function automatic logic op_a_signed(input muldiv_op_t op);
    return (op == MULDIV_OP_MULH) || (op == MULDIV_OP_MULHSU) ||
           (op == MULDIV_OP_DIV)  || (op == MULDIV_OP_REM);
  endfunction

  // rs2 is treated as signed (MULHSU keeps rs2 unsigned).
  function automatic logic op_b_signed(input muldiv_op_t op);
    return (op == MULDIV_OP_MULH) || (op == MULDIV_OP_DIV) ||
           (op == MULDIV_OP_REM);
  endfunction

  function automatic logic op_is_div(input muldiv_op_t op);
    return op[2];
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the EX stage and the multiply/divide unit.
//  master (core) drives: flush, in_valid, op, a, b, out_ready
//  slave  (unit) drives: in_ready, out_valid, result, busy
interface muldiv_unit_if
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN = 32
) ();

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  muldiv_op_t       op;
  logic [XLEN-1:0]  a;
  logic [XLEN-1:0]  b;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  result;
  logic             busy;

  modport master (
    output flush, in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  flush, in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, busy
  );

endinterface

// File: rtl/muldiv_sign_fix.sv
// Combinational conditional two's-complement negation of an XLEN value.
//  value    in  XLEN  word to fix
//  negate   in  1     1: output ~value + carry_in, 0: pass value through
//  carry_in in  1     increment applied on negation; lets the upper word of
//                     a wide negation take the borrow from the lower word
//  fixed    out XLEN  result
// Used for operand magnitudes on accept and for the final sign fix.
module muldiv_sign_fix #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] value,
  input  logic            negate,
  input  logic            carry_in,
  output logic [XLEN-1:0] fixed
);

  assign fixed = negate ? (~value + {{(XLEN-1){1'b0}}, carry_in}) : value;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit.
//  clk  in  clock, all state on posedge
//  rst  in  asynchronous active-high reset
//  bus  slave side of muldiv_unit_if (flush, valid/ready request carrying
//       op/a/b, valid/ready response carrying result, busy)
// Operand magnitudes are latched on accept, one product/quotient bit is
// produced per cycle for XLEN cycles, and the sign is reapplied in FIXUP.
// Division by zero and signed overflow can skip the iteration (EARLY_OUT).
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  muldiv_unit_if.slave    bus
);

  localparam int             CW       = $clog2(XLEN);
  localparam logic [CW-1:0]  CNT_LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_t     state_reg, state_next;
  logic [CW-1:0]     cnt_reg, cnt_next;
  muldiv_op_t        op_reg, op_next;
  logic [XLEN-1:0]   opnd_reg, opnd_next;     // multiplicand or divisor magnitude
  logic [2*XLEN-1:0] acc_reg, acc_next;       // product accumulator, multiplier in low half
  logic [XLEN:0]     rem_reg, rem_next;       // partial remainder
  logic [XLEN-1:0]   quot_reg, quot_next;     // dividend bits shifting out, quotient bits in
  logic              neg_reg, neg_next;       // final result must be negated
  logic [XLEN-1:0]   result_reg, result_next;

  logic              accept;
  logic              sign_a, sign_b, div_zero, div_ovf, early;
  logic [XLEN-1:0]   a_fix_out, b_abs;
  logic [XLEN-1:0]   fix_word;
  logic              fix_cin;
  logic              in_fixup;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     rem_shift;
  logic              rem_ge;

  // Operand classification on the incoming request
  assign sign_a   = op_a_signed(bus.op) & bus.a[XLEN-1];
  assign sign_b   = op_b_signed(bus.op) & bus.b[XLEN-1];
  assign div_zero = op_is_div(bus.op) && (bus.b == '0);
  assign div_ovf  = ((bus.op == MULDIV_OP_DIV) || (bus.op == MULDIV_OP_REM)) &&
                    (bus.a == INT_MIN) && (bus.b == '1);
  assign early    = EARLY_OUT && (div_zero || div_ovf);
  assign accept   = (state_reg == ST_IDLE) && bus.in_valid && !bus.flush;
  assign in_fixup = (state_reg == ST_FIXUP);

  // Word selection for the final sign fix. Negating the high half of the
  // 2*XLEN product only carries in when the whole low half is zero.
  always_comb begin
    fix_word = quot_reg;
    fix_cin  = 1'b1;
    case (op_reg)
      MULDIV_OP_MUL: fix_word = acc_reg[XLEN-1:0];
      MULDIV_OP_MULH, MULDIV_OP_MULHSU, MULDIV_OP_MULHU: begin
        fix_word = acc_reg[2*XLEN-1:XLEN];
        fix_cin  = (acc_reg[XLEN-1:0] == '0);
      end
      MULDIV_OP_REM, MULDIV_OP_REMU: fix_word = rem_reg[XLEN-1:0];
      default: fix_word = quot_reg;
    endcase
  end

  // Shared: takes |a| while idle, applies the result sign during FIXUP
  muldiv_sign_fix #(.XLEN(XLEN)) u_fix_a (
    .value    (in_fixup ? fix_word : bus.a),
    .negate   (in_fixup ? neg_reg  : sign_a),
    .carry_in (in_fixup ? fix_cin  : 1'b1),
    .fixed    (a_fix_out)
  );

  muldiv_sign_fix #(.XLEN(XLEN)) u_fix_b (
    .value    (bus.b),
    .negate   (sign_b),
    .carry_in (1'b1),
    .fixed    (b_abs)
  );

  // One iteration step of each algorithm
  assign mul_sum   = {1'b0, acc_reg[2*XLEN-1:XLEN]} +
                     (acc_reg[0] ? {1'b0, opnd_reg} : '0);
  assign rem_shift = {rem_reg[XLEN-1:0], quot_reg[XLEN-1]};
  assign rem_ge    = (rem_shift >= {1'b0, opnd_reg});

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    op_next     = op_reg;
    opnd_next   = opnd_reg;
    acc_next    = acc_reg;
    rem_next    = rem_reg;
    quot_next   = quot_reg;
    neg_next    = neg_reg;
    result_next = result_reg;

    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          op_next  = bus.op;
          cnt_next = '0;
          if (op_is_div(bus.op)) begin
            opnd_next = b_abs;
            // Early divide-by-zero preloads the architectural answer:
            // quotient all ones, remainder the dividend.
            quot_next = (early && div_zero) ? '1 : a_fix_out;
            rem_next  = (early && div_zero) ? {1'b0, a_fix_out} : '0;
            // Quotient by zero stays all ones regardless of dividend sign
            neg_next  = bus.op[1] ? sign_a : ((sign_a ^ sign_b) && !div_zero);
          end else begin
            opnd_next = a_fix_out;
            acc_next  = {{XLEN{1'b0}}, b_abs};
            neg_next  = sign_a ^ sign_b;
          end
          state_next = early ? ST_FIXUP : ST_CALC;
        end
      end
      ST_CALC: begin
        if (op_is_div(op_reg)) begin
          rem_next  = rem_ge ? (rem_shift - {1'b0, opnd_reg}) : rem_shift;
          quot_next = {quot_reg[XLEN-2:0], rem_ge};
        end else begin
          acc_next  = {mul_sum, acc_reg[XLEN-1:1]};
        end
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == CNT_LAST) state_next = ST_FIXUP;
      end
      ST_FIXUP: begin
        if (!bus.flush) result_next = a_fix_out;
        state_next = ST_DONE;
      end
      ST_DONE: begin
        if (bus.out_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase

    // A redirect wins over everything, including a pending out_ready
    if (bus.flush) state_next = ST_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      op_reg     <= MULDIV_OP_MUL;
      opnd_reg   <= '0;
      acc_reg    <= '0;
      rem_reg    <= '0;
      quot_reg   <= '0;
      neg_reg    <= 1'b0;
      result_reg <= '0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      op_reg     <= op_next;
      opnd_reg   <= opnd_next;
      acc_reg    <= acc_next;
      rem_reg    <= rem_next;
      quot_reg   <= quot_next;
      neg_reg    <= neg_next;
      result_reg <= result_next;
    end
  end

  assign bus.in_ready  = (state_reg == ST_IDLE);
  assign bus.out_valid = (state_reg == ST_DONE);
  assign bus.busy      = (state_reg != ST_IDLE);
  assign bus.result    = result_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (XLEN=32, EARLY_OUT=1): directed
// vector table, handshake/flush/reset sequences, then random operations
// checked against an arithmetic reference model.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  muldiv_unit_if #(.XLEN(XLEN)) bus ();

  muldiv_unit #(.XLEN(XLEN), .EARLY_OUT(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, got, exp);
    end
  endtask

  // Reference model: RISC-V M-extension semantics in plain arithmetic
  function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] ps;
    logic [63:0]        pu;
    logic signed [31:0] sx;
    logic signed [31:0] sy;
    logic               ovf;
    sx  = x;
    sy  = y;
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    case (o)
      3'd0: begin ps = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y}); return ps[31:0]; end
      3'd1: begin ps = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y}); return ps[63:32]; end
      3'd2: begin ps = $signed({{32{x[31]}}, x}) * $signed({32'b0, y}); return ps[63:32]; end
      3'd3: begin pu = {32'b0, x} * {32'b0, y}; return pu[63:32]; end
      3'd4: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (ovf) return x;
        return sx / sy;
      end
      3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'd6: begin
        if (y == 0) return x;
        if (ovf) return 32'h0;
        return sx % sy;
      end
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    if (o[2] && y == 0) return 2;
    if ((o == 3'd4 || o == 3'd6) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 2;
    return XLEN + 2;
  endfunction

  // Present a request for one edge, then scramble the inputs so any
  // late sampling shows up as a wrong result.
  task automatic start_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    bus.op = o; bus.a = x; bus.b = y; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.op = 3'($urandom);
    bus.a  = $urandom;
    bus.b  = $urandom;
  endtask

  // Latency counted from the accept edge (1) to the edge raising out_valid
  task automatic wait_done(output int lat);
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic finish_op();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic full_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] exp, input int exp_lat);
    int lat;
    logic [31:0] res;
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    start_op(o, x, y);
    wait_done(lat);
    res = bus.result;
    check({tag, "_result"}, res, exp);
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    $display("%s op=%0d a=%08h b=%08h result=%08h lat=%0d", tag, o, x, y, res, lat);
    finish_op();
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  vec_t tbl[16];

  initial begin
    int lat;
    logic seen;
    logic [2:0]  ro;
    logic [31:0] ra, rb;

    tbl[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34};
    tbl[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34};
    tbl[2]  = '{3'd3, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34};
    tbl[3]  = '{3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 34};
    tbl[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34};
    tbl[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34};
    tbl[6]  = '{3'd5, 32'd100,        32'd7,         32'd14,        34};
    tbl[7]  = '{3'd7, 32'd100,        32'd7,         32'd2,         34};
    tbl[8]  = '{3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, 2};
    tbl[9]  = '{3'd6, 32'd5,          32'd0,         32'd5,         2};
    tbl[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 2};
    tbl[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         2};
    tbl[12] = '{3'd5, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFFF, 2};
    tbl[13] = '{3'd7, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9, 2};
    tbl[14] = '{3'd5, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         34};
    tbl[15] = '{3'd4, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFFF, 2};

    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.op = 3'd0; bus.a = '0; bus.b = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready",  32'(bus.in_ready),  32'd1);
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_busy",      32'(bus.busy),      32'd0);
    check("reset_result",    bus.result,         32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed vectors
    for (int i = 0; i < 16; i++)
      full_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].lat);

    // Back-pressure: result held while out_ready is low
    start_op(3'd0, 32'd7, 32'hFFFF_FFFD);
    wait_done(lat);
    check("hold_latency", 32'(lat), 32'd34);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("hold_out_valid", 32'(bus.out_valid), 32'd1);
      check("hold_result",    bus.result,         32'hFFFF_FFEB);
      check("hold_in_ready",  32'(bus.in_ready),  32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("release_in_ready",  32'(bus.in_ready),  32'd1);
    check("release_out_valid", 32'(bus.out_valid), 32'd0);
    $display("hold sequence: 5 stalled cycles then release");

    // Flush in CALC at cnt=10
    start_op(3'd4, 32'd1000, 32'd7);
    repeat (10) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("flush_busy",     32'(bus.busy),     32'd0);
    check("flush_in_ready", 32'(bus.in_ready), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) seen = 1'b1;
    end
    check("flush_no_out_valid", 32'(seen), 32'd0);
    $display("flush in CALC: unit returned to idle");

    // Flush together with in_valid in IDLE: request must be refused
    bus.op = 3'd0; bus.a = 32'd3; bus.b = 32'd3;
    bus.in_valid = 1'b1; bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.flush = 1'b0;
    check("flush_idle_busy", 32'(bus.busy), 32'd0);
    full_op("after_flush", 3'd7, 32'd1000, 32'd7, 32'd6, 34);

    // Flush in DONE beats out_ready
    start_op(3'd1, 32'h1234_5678, 32'h9ABC_DEF0);
    wait_done(lat);
    bus.flush = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.out_ready = 1'b0;
    check("flush_done_out_valid", 32'(bus.out_valid), 32'd0);
    check("flush_done_in_ready",  32'(bus.in_ready),  32'd1);

    // Asynchronous reset mid-operation
    start_op(3'd6, 32'hFFFF_FC18, 32'd7);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rst_mid_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_mid_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_mid_busy",      32'(bus.busy),      32'd0);
    check("rst_mid_result",    bus.result,         32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    full_op("after_rst", 3'd6, 32'hFFFF_FC18, 32'd7,
            ref_result(3'd6, 32'hFFFF_FC18, 32'd7), 34);

    // Randomized operations against the reference model
    for (int i = 0; i < 150; i++) begin
      ro = 3'($urandom);
      ra = rnd_operand();
      rb = rnd_operand();
      full_op($sformatf("rnd%0d", i), ro, ra, rb, ref_result(ro, ra, rb), ref_latency(ro, ra, rb));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
